// File: rtl/power_iter_pkg.sv
// Shared types for the power_iter block: FSM state encoding, the reset state,
// and a helper that picks the state entered when an operand pair is accepted.
package power_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t STATE_RESET = IDLE;

  // A zero exponent has nothing to multiply, so the result (1) is ready at once.
  function automatic state_t accept_target(input logic n_is_zero);
    return n_is_zero ? DONE : CALC;
  endfunction

endpackage

// File: rtl/power_iter_mul.sv
// Combinational W x W -> 2W unsigned multiplier. Kept in its own module so a
// DSP-mapped or pipelined variant can be dropped in without touching the
// sequencing in power_iter.
module power_iter_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;

  assign a_ext = {{W{1'b0}}, a};
  assign b_ext = {{W{1'b0}}, b};

  // Full-width product; the upper half is only used for overflow detection.
  assign p = a_ext * b_ext;

endmodule

// File: rtl/power_iter.sv
// power_iter: iterative x^n mod 2^W with a runtime exponent, one multiply per
// cycle, valid/ready on both sides. Operands are captured at accept and the
// result is held under backpressure.
// Optional build macro: POWER_ITER_OVERFLOW_EN drives o_overflow with a sticky
// flag that is set when any intermediate product needs more than W bits.
module power_iter
  import power_iter_pkg::*;
#(
  parameter int W   = 8,
  parameter int N_W = 4
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic [W-1:0]   i_x,
  input  logic [N_W-1:0] i_n,
  input  logic           i_valid,
  output logic           o_ready,
  output logic [W-1:0]   o_xPower,
  output logic           o_valid,
  input  logic           i_ready,
  output logic           o_overflow
);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   x_q;
  logic [W-1:0]   xPower_q;
  logic [N_W-1:0] count_q;
  logic [2*W-1:0] prod;
  logic           accept;
  logic           in_calc;
  logic           last_calc;

  // Ready in IDLE, or in DONE when the consumer takes the result this cycle
  // so a new pair can follow back-to-back.
  assign o_ready   = (state_q == IDLE) || ((state_q == DONE) && i_ready);
  assign accept    = i_valid && o_ready;
  assign in_calc   = (state_q == CALC);
  assign last_calc = in_calc && (count_q == N_W'(1));

  assign o_valid   = (state_q == DONE);
  assign o_xPower  = xPower_q;

  power_iter_mul #(
    .W (W)
  ) u_mul (
    .a (xPower_q),
    .b (x_q),
    .p (prod)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= STATE_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = accept_target(i_n == '0);
        end
      end
      CALC: begin
        if (last_calc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_d = accept_target(i_n == '0);
        end else if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = STATE_RESET;
      end
    endcase
  end

  // Operand capture at accept, then one multiply and one decrement per CALC cycle.
  // count_q is at least 1 whenever CALC is active, so the decrement never wraps.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      x_q      <= '0;
      count_q  <= '0;
      xPower_q <= W'(1);
    end else if (accept) begin
      x_q      <= i_x;
      count_q  <= i_n;
      xPower_q <= W'(1);
    end else if (in_calc) begin
      xPower_q <= prod[W-1:0];
      count_q  <= count_q - N_W'(1);
    end
  end

`ifdef POWER_ITER_OVERFLOW_EN
  logic overflow_q;

  // Sticky per-operation overflow: cleared on accept, set by any wide product.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      overflow_q <= 1'b0;
    end else if (accept) begin
      overflow_q <= 1'b0;
    end else if (in_calc && (|prod[2*W-1:W])) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_overflow = overflow_q;
`else
  logic unused_prod_hi;

  // Without overflow tracking the upper product half has no consumer.
  assign unused_prod_hi = |prod[2*W-1:W];
  assign o_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_power_iter.sv
// Scoreboard bench for power_iter (W=8, N_W=4): the driver pushes expected
// results from a plain arithmetic model, a monitor pops and compares them.
module tb_power_iter;

  localparam int W   = 8;
  localparam int N_W = 4;

  logic           i_clk    = 1'b0;
  logic           i_arst_n = 1'b0;
  logic [W-1:0]   i_x      = '0;
  logic [N_W-1:0] i_n      = '0;
  logic           i_valid  = 1'b0;
  logic           i_ready  = 1'b1;
  logic           o_ready;
  logic [W-1:0]   o_xPower;
  logic           o_valid;
  logic           o_overflow;

  power_iter #(.W(W), .N_W(N_W)) dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_x        (i_x),
    .i_n        (i_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_xPower   (o_xPower),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] res;
    bit           ov;
    int           n;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // x^n mod 2^W; overflow means the true power x^n no longer fits in W bits.
  function automatic void model(input logic [W-1:0] x, input logic [N_W-1:0] n,
                                output logic [W-1:0] r, output bit ov);
    int e;
    e  = 1;
    r  = W'(1);
    ov = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      r = r * x;
      e = e * int'(x);
      if (e >= (1 << W)) begin
        ov = 1'b1;
        e  = 1 << W;
      end
    end
`ifndef POWER_ITER_OVERFLOW_EN
    ov = 1'b0;
`endif
  endfunction

  // Offer a pair until accepted; push the expected response at the accept edge.
  task automatic send(input bit sync, input logic [W-1:0] x, input logic [N_W-1:0] n);
    logic [W-1:0] r;
    bit           ov;
    exp_t         e;
    int           waitc;
    waitc = 0;
    if (sync) @(negedge i_clk);
    i_x = x;
    i_n = n;
    i_valid = 1'b1;
    #1;
    while (!o_ready) begin
      waitc++;
      if (waitc > 200) begin
        errors++;
        checks++;
        $display("FAIL accept_timeout: o_ready=%0d, expected 1 within 200 cycles", o_ready);
        i_valid = 1'b0;
        return;
      end
      @(negedge i_clk);
      #1;
    end
    model(x, n, r, ov);
    e.res = r;
    e.ov  = ov;
    e.n   = int'(n);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_x = W'($urandom);
    i_n = N_W'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge i_clk);
      w++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: pending=%0d, expected 0", sb.size());
    end
  endtask

  // Random downstream backpressure, changed away from both clock edges.
  initial begin
    forever begin
      @(posedge i_clk);
      if (rand_rdy) begin
        #2;
        i_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: latency on first presentation, stability while held, value on handshake.
  initial begin
    bit           pv;
    bit           phs;
    bit           first;
    logic [W-1:0] pres;
    pv = 1'b0;
    phs = 1'b0;
    pres = '0;
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_arst_n) begin
        check("rst_valid", 32'(o_valid), 32'd0);
        pv  = 1'b0;
        phs = 1'b0;
      end else begin
        first = o_valid && (!pv || phs);
        if (o_valid) begin
          if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL spurious_valid: o_valid=1 o_xPower=%0d, expected no result", o_xPower);
          end else begin
            if (first) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].n));
            else       check("hold_stable", 32'(o_xPower), 32'(pres));
            if (i_ready) begin
              check("result", 32'(o_xPower), 32'(sb[0].res));
              check("overflow", 32'(o_overflow), 32'(sb[0].ov));
              void'(sb.pop_front());
            end
          end
          pres = o_xPower;
        end
        pv  = o_valid;
        phs = o_valid && i_ready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset, then idle.
    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_xpower", 32'(o_xPower), 32'd1);
    i_arst_n = 1'b1;
    @(negedge i_clk);
    #1;
    check("idle_valid", 32'(o_valid), 32'd0);
    check("idle_ready", 32'(o_ready), 32'd1);
    check("idle_overflow", 32'(o_overflow), 32'd0);

    // Directed exponents, zero exponents, wrap and overflow.
    send(1'b1, 8'd3, 4'd3);
    send(1'b1, 8'd7, 4'd1);
    send(1'b1, 8'd5, 4'd0);
    send(1'b1, 8'd0, 4'd0);
    send(1'b1, 8'd2, 4'd8);
    send(1'b1, 8'd2, 4'd7);
    send(1'b1, 8'd255, 4'd15);
    send(1'b1, 8'd1, 4'd15);
    drain();

    // Backpressure: hold the result for 5 cycles while a busy-time offer is ignored.
    @(negedge i_clk);
    i_ready = 1'b0;
    send(1'b0, 8'd4, 4'd2);
    w = 0;
    while (!o_valid && w < 50) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    check("bp_valid", 32'(o_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      i_x = 8'd9;
      i_n = 4'd1;
      #1;
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_hold", 32'(o_xPower), 32'd16);
      @(negedge i_clk);
      #1;
    end
    // Release and accept a new pair in the same cycle.
    i_ready = 1'b1;
    send(1'b0, 8'd3, 4'd2);
    drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 120; k++) begin
      send(1'b1, W'($urandom), N_W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    drain();
    @(negedge i_clk);
    rand_rdy = 1'b0;
    i_ready = 1'b1;

    // Reset in the middle of a long operation aborts it without a result.
    send(1'b1, 8'd3, 4'd15);
    repeat (3) @(negedge i_clk);
    i_arst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_valid", 32'(o_valid), 32'd0);
    repeat (2) @(negedge i_clk);
    i_arst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1;
      check("postrst_valid", 32'(o_valid), 32'd0);
      check("postrst_ready", 32'(o_ready), 32'd1);
    end
    send(1'b1, 8'd2, 4'd4);
    drain();
    repeat (3) @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
